// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared types and constants for the 16-bit load/store unit.
// Rev    : 1.0  initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RSP  = 2'd3
    } lsu_state_e;

    localparam int DEFAULT_MEM_BYTES = 128;

    localparam logic [1:0] NO_ERROR     = 2'd0;
    localparam logic [1:0] MISALIGNED   = 2'd1;
    localparam logic [1:0] OUT_OF_RANGE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module : load_store_unit_if
// Brief  : Request/response channels plus data-memory port of the LSU.
// Rev    : 1.0  initial release
// ============================================================================
interface load_store_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              ReqValid;
    logic              ReqReady;
    logic              ReqWrite;
    logic              ReqByte;
    logic              ReqSigned;
    logic [ADDR_W-1:0] ReqAddr;
    logic [DATA_W-1:0] ReqWData;
    logic              RspValid;
    logic              RspReady;
    logic [DATA_W-1:0] RspRData;
    logic              RspError;
    logic [ADDR_W-1:0] MemAdresa;
    logic [DATA_W-1:0] MemWriteData;
    logic              MemWrite;
    logic              MemRead;
    logic [DATA_W-1:0] MemReadData;

    modport master (
        input  ReqValid, ReqWrite, ReqByte, ReqSigned, ReqAddr, ReqWData,
        input  RspReady, MemReadData,
        output ReqReady, RspValid, RspRData, RspError,
        output MemAdresa, MemWriteData, MemWrite, MemRead
    );

    modport slave (
        output ReqValid, ReqWrite, ReqByte, ReqSigned, ReqAddr, ReqWData,
        output RspReady, MemReadData,
        input  ReqReady, RspValid, RspRData, RspError,
        input  MemAdresa, MemWriteData, MemWrite, MemRead
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit_byte_lane.sv
`default_nettype none
// ============================================================================
// Module : lsu_byte_lane
// Brief  : Byte select/extend for loads and byte merge for RMW stores.
// Rev    : 1.0  initial release
// ============================================================================
module lsu_byte_lane (
    input  wire logic [15:0] i_rdata,
    input  wire logic        i_addr_lsb,
    input  wire logic        i_is_byte,
    input  wire logic        i_sign_ext,
    input  wire logic [7:0]  i_wbyte,
    output logic      [15:0] o_load,
    output logic      [15:0] o_merge
);
    logic [7:0] w_sel;

    // Big-endian: the even address owns the upper lane.
    always_comb begin
        w_sel   = i_addr_lsb ? i_rdata[7:0] : i_rdata[15:8];
        o_load  = i_is_byte ? {{8{i_sign_ext & w_sel[7]}}, w_sel} : i_rdata;
        o_merge = i_addr_lsb ? {i_rdata[15:8], i_wbyte} : {i_wbyte, i_rdata[7:0]};
    end
endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : load_store_unit
// Brief  : One-at-a-time load/store initiator for a 16-bit big-endian memory.
// Rev    : 1.0  initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_BYTES = DEFAULT_MEM_BYTES
) (
    input  wire logic         Clock,
    input  wire logic         ResetN,
    load_store_unit_if.master bus
);
    localparam logic [1:0]      c_IDLE      = ST_IDLE;
    localparam logic [1:0]      c_RD        = ST_RD;
    localparam logic [1:0]      c_WR        = ST_WR;
    localparam logic [1:0]      c_RSP       = ST_RSP;
    localparam logic [ADDR_W:0] c_MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W:0] c_ONE       = (ADDR_W+1)'(1);

    logic [1:0]        r_state;
    logic              r_write;
    logic              r_byte;
    logic              r_signed;
    logic              r_addr_lsb;
    logic [7:0]        r_wbyte;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;

    logic [ADDR_W:0]   w_addr_ext;
    logic [ADDR_W:0]   w_last;
    logic [ADDR_W-1:0] w_base;
    logic [1:0]        w_cause;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merge;

    // One extra bit keeps the last-byte address from wrapping at the top.
    always_comb begin
        w_addr_ext = {1'b0, bus.ReqAddr};
        w_last     = bus.ReqByte ? w_addr_ext : w_addr_ext + c_ONE;
        w_base     = bus.ReqByte ? {bus.ReqAddr[ADDR_W-1:1], 1'b0} : bus.ReqAddr;
        w_cause    = NO_ERROR;
        if (!bus.ReqByte && bus.ReqAddr[0])
            w_cause = MISALIGNED;
        else if (w_last >= c_MEM_LIMIT)
            w_cause = OUT_OF_RANGE;
    end

    // Lane logic sees live read data during RD, so its results are exactly
    // what the holding register would present one cycle later.
    lsu_byte_lane u_byte_lane (
        .i_rdata    (bus.MemReadData),
        .i_addr_lsb (r_addr_lsb),
        .i_is_byte  (r_byte),
        .i_sign_ext (r_signed),
        .i_wbyte    (r_wbyte),
        .o_load     (w_load),
        .o_merge    (w_merge)
    );

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            r_state     <= c_IDLE;
            r_write     <= 1'b0;
            r_byte      <= 1'b0;
            r_signed    <= 1'b0;
            r_addr_lsb  <= 1'b0;
            r_wbyte     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.ReqValid) begin
                        r_write    <= bus.ReqWrite;
                        r_byte     <= bus.ReqByte;
                        r_signed   <= bus.ReqSigned;
                        r_addr_lsb <= bus.ReqAddr[0];
                        r_wbyte    <= bus.ReqWData[7:0];
                        if (w_cause != NO_ERROR) begin
                            r_rsp_err  <= 1'b1;
                            r_rsp_data <= '0;
                            r_state    <= c_RSP;
                        end else begin
                            r_rsp_err  <= 1'b0;
                            r_mem_addr <= w_base;
                            if (bus.ReqWrite && !bus.ReqByte) begin
                                r_mem_wdata <= bus.ReqWData;
                                r_state     <= c_WR;
                            end else begin
                                r_state <= c_RD;
                            end
                        end
                    end
                end
                c_RD: begin
                    if (r_write) begin
                        r_mem_wdata <= w_merge;
                        r_state     <= c_WR;
                    end else begin
                        r_rsp_data <= w_load;
                        r_state    <= c_RSP;
                    end
                end
                c_WR: begin
                    r_rsp_data <= '0;
                    r_state    <= c_RSP;
                end
                c_RSP: begin
                    if (bus.RspReady)
                        r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.ReqReady     = (r_state == c_IDLE);
    assign bus.RspValid     = (r_state == c_RSP);
    assign bus.RspRData     = r_rsp_data;
    assign bus.RspError     = r_rsp_err;
    assign bus.MemAdresa    = r_mem_addr;
    assign bus.MemWriteData = r_mem_wdata;
    assign bus.MemRead      = (r_state == c_RD);
    // Gated by reset so an interrupted store can never commit.
    assign bus.MemWrite     = (r_state == c_WR) && ResetN;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_load_store_unit
// Brief  : Directed and randomized checks of load_store_unit against a
//          byte-array memory model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    logic Clock  = 1'b0;
    logic ResetN = 1'b0;
    always #5 Clock = ~Clock;

    load_store_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    load_store_unit #(.ADDR_W(16), .DATA_W(16), .MEM_BYTES(128)) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (bus.master)
    );

    logic [7:0] mem      [0:127];
    logic [7:0] init_mem [0:127];
    logic [7:0] ref_mem  [0:127];
    bit         init_done = 1'b0;
    int         n_chk  = 0;
    int         n_pass = 0;

    function automatic logic [7:0] rd_byte(input int a);
        return (a >= 0 && a < 128) ? mem[a] : 8'h00;
    endfunction

    always_comb bus.MemReadData = {rd_byte(int'(bus.MemAdresa)), rd_byte(int'(bus.MemAdresa) + 1)};

    always @(posedge Clock) begin
        if (!init_done) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_mem[i];
        end else if (bus.MemWrite) begin
            if (int'(bus.MemAdresa) < 128)     mem[bus.MemAdresa]         <= bus.MemWriteData[15:8];
            if (int'(bus.MemAdresa) + 1 < 128) mem[int'(bus.MemAdresa)+1] <= bus.MemWriteData[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_req(input string tag, input bit wr, input bit bt, input bit sg,
                          input logic [15:0] addr, input logic [15:0] wd);
        int          lastb, exp_lat, exp_rd, exp_wr, lat, nrd, nwr;
        bit          exp_err;
        logic [15:0] base, exp_data, exp_wdata, rd_a, wr_a, wr_d;
        logic [7:0]  b;
        lastb     = int'(addr) + (bt ? 0 : 1);
        base      = bt ? (addr & 16'hFFFE) : addr;
        exp_err   = (!bt && addr[0]) || (lastb >= 128);
        exp_data  = 16'h0;
        exp_wdata = 16'h0;
        exp_rd    = 0;
        exp_wr    = 0;
        if (exp_err) begin
            exp_lat = 1;
        end else if (!wr) begin
            exp_lat = 2;
            exp_rd  = 1;
            if (bt) begin
                b        = ref_mem[addr];
                exp_data = sg ? {{8{b[7]}}, b} : {8'h00, b};
            end else begin
                exp_data = {ref_mem[addr], ref_mem[addr + 16'd1]};
            end
        end else if (bt) begin
            exp_lat       = 3;
            exp_rd        = 1;
            exp_wr        = 1;
            ref_mem[addr] = wd[7:0];
            exp_wdata     = {ref_mem[base], ref_mem[base + 16'd1]};
        end else begin
            exp_lat               = 2;
            exp_wr                = 1;
            ref_mem[addr]         = wd[15:8];
            ref_mem[addr + 16'd1] = wd[7:0];
            exp_wdata             = wd;
        end

        check({tag, "/ready"}, bus.ReqReady, 1);
        bus.ReqValid  = 1'b1;
        bus.ReqWrite  = wr;
        bus.ReqByte   = bt;
        bus.ReqSigned = sg;
        bus.ReqAddr   = addr;
        bus.ReqWData  = wd;
        tick();
        bus.ReqValid = 1'b0;

        lat = 1; nrd = 0; nwr = 0;
        rd_a = 16'h0; wr_a = 16'h0; wr_d = 16'h0;
        while (!bus.RspValid && lat < 8) begin
            if (bus.MemRead)  begin nrd++; rd_a = bus.MemAdresa; end
            if (bus.MemWrite) begin nwr++; wr_a = bus.MemAdresa; wr_d = bus.MemWriteData; end
            tick();
            lat++;
        end
        check({tag, "/latency"}, lat, exp_lat);
        check({tag, "/error"}, bus.RspError, exp_err);
        check({tag, "/rdata"}, bus.RspRData, exp_data);
        check({tag, "/reads"}, nrd, exp_rd);
        check({tag, "/writes"}, nwr, exp_wr);
        if (exp_rd != 0) check({tag, "/rd_addr"}, rd_a, base);
        if (exp_wr != 0) begin
            check({tag, "/wr_addr"}, wr_a, base);
            check({tag, "/wr_data"}, wr_d, exp_wdata);
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          bad;
        int          r;
        logic [15:0] a;
        bus.ReqValid  = 1'b0;
        bus.ReqWrite  = 1'b0;
        bus.ReqByte   = 1'b0;
        bus.ReqSigned = 1'b0;
        bus.ReqAddr   = 16'h0;
        bus.ReqWData  = 16'h0;
        bus.RspReady  = 1'b1;
        for (int i = 0; i < 128; i++) init_mem[i] = 8'($urandom);
        init_mem[16'h10] = 8'hAB;
        init_mem[16'h11] = 8'hCD;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_mem[i];

        ResetN = 1'b0;
        tick();
        tick();
        check("rst/ReqReady", bus.ReqReady, 1);
        check("rst/RspValid", bus.RspValid, 0);
        check("rst/RspError", bus.RspError, 0);
        check("rst/RspRData", bus.RspRData, 0);
        check("rst/MemWrite", bus.MemWrite, 0);
        check("rst/MemRead", bus.MemRead, 0);
        check("rst/MemAdresa", bus.MemAdresa, 0);
        check("rst/MemWriteData", bus.MemWriteData, 0);
        ResetN    = 1'b1;
        init_done = 1'b1;

        do_req("ld_hw_10", 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0);
        do_req("ld_sb_10", 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0);
        do_req("ld_ub_11", 1'b0, 1'b1, 1'b0, 16'h0011, 16'h0);

        // Backpressure with an ignored competing store.
        bus.RspReady  = 1'b0;
        bus.ReqValid  = 1'b1;
        bus.ReqWrite  = 1'b0;
        bus.ReqByte   = 1'b0;
        bus.ReqAddr   = 16'h0010;
        tick();
        bus.ReqValid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("bp/RspValid", bus.RspValid, 1);
            check("bp/RspRData", bus.RspRData, {ref_mem[16'h10], ref_mem[16'h11]});
            check("bp/ReqReady", bus.ReqReady, 0);
            check("bp/MemWrite", bus.MemWrite, 0);
            bus.ReqValid = 1'b1;
            bus.ReqWrite = 1'b1;
            bus.ReqWData = 16'hFFFF;
            tick();
        end
        bus.ReqValid = 1'b0;
        bus.RspReady = 1'b1;
        tick();
        check("bp/ReqReady_after", bus.ReqReady, 1);
        check("bp/RspValid_after", bus.RspValid, 0);

        do_req("st_b_11", 1'b1, 1'b1, 1'b0, 16'h0011, 16'h005A);
        do_req("ld_hw_10b", 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0);
        do_req("err_ld_hw_11", 1'b0, 1'b0, 1'b0, 16'h0011, 16'h0);
        do_req("err_st_hw_7f", 1'b1, 1'b0, 1'b0, 16'h007F, 16'hBEEF);
        do_req("err_ld_b_80", 1'b0, 1'b1, 1'b0, 16'h0080, 16'h0);
        do_req("ld_hw_7e", 1'b0, 1'b0, 1'b0, 16'h007E, 16'h0);
        do_req("ld_b_7f", 1'b0, 1'b1, 1'b1, 16'h007F, 16'h0);
        do_req("err_ld_b_ffff", 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0);
        do_req("err_ld_hw_fffe", 1'b0, 1'b0, 1'b0, 16'hFFFE, 16'h0);

        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 15));
            a = (r == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF)) : 16'($urandom_range(0, 16'h0084));
            do_req($sformatf("rnd%0d", k), 1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom));
        end

        // Reset landing on the WR cycle of a halfword store.
        bus.ReqValid = 1'b1;
        bus.ReqWrite = 1'b1;
        bus.ReqByte  = 1'b0;
        bus.ReqAddr  = 16'h0020;
        bus.ReqWData = 16'h1234;
        tick();
        bus.ReqValid = 1'b0;
        ResetN       = 1'b0;
        #1;
        check("midrst/MemWrite", bus.MemWrite, 0);
        tick();
        ResetN = 1'b1;
        check("midrst/ReqReady", bus.ReqReady, 1);
        check("midrst/RspValid", bus.RspValid, 0);
        check("midrst/mem20", mem[16'h20], ref_mem[16'h20]);
        check("midrst/mem21", mem[16'h21], ref_mem[16'h21]);

        do_req("post_rst_ld_20", 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0);

        bad = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("mem_final_mismatches", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
